// File: rtl/drum_step_sequencer.sv
// Tempo-driven drum step sequencer: walks a per-voice on/off pattern at a
// programmable step period and emits fixed-width trigger pulses per voice.
module drum_step_sequencer #(
    parameter int NUM_VOICES  = 4,
    parameter int NUM_STEPS   = 16,
    parameter int TRIG_CYCLES = 1000,
    parameter int MIN_PERIOD  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          play,
    input  logic [31:0]                   step_period,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_VOICES)-1:0] wr_voice,
    input  logic [$clog2(NUM_STEPS)-1:0]  wr_step,
    input  logic                          wr_data,
    output logic                          running,
    output logic                          step_tick,
    output logic [$clog2(NUM_STEPS)-1:0]  step_idx,
    output logic [NUM_VOICES-1:0]         trig
);

    localparam int SW = $clog2(NUM_STEPS);
    localparam int TW = $clog2(TRIG_CYCLES + 1);
    localparam logic [31:0]   MIN_P     = 32'(MIN_PERIOD);
    localparam logic [TW-1:0] TRIG_LOAD = TW'(TRIG_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_next;

    logic [31:0]          period_cnt;
    logic [31:0]          period_q;
    logic [31:0]          period_new;
    logic [31:0]          period_cur;
    logic [SW-1:0]        step_q;
    logic [NUM_STEPS-1:0] pattern [NUM_VOICES];
    logic [TW-1:0]        trig_cnt [NUM_VOICES];
    logic                 active;
    logic                 tick;
    logic                 wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (play)  state_next = RUN;
            RUN:  if (!play) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        running   = (state == RUN);
        step_tick = (state == RUN) && (period_cnt == 32'd0);
        step_idx  = step_q;
        trig      = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            trig[v] = (trig_cnt[v] != '0);
        end
    end

    // The step just starting uses the freshly clamped period; later cycles of
    // that step use the latched copy so mid-step period changes are ignored.
    always_comb begin
        active     = (state == RUN) && play;
        tick       = (state == RUN) && (period_cnt == 32'd0);
        period_new = (step_period < MIN_P) ? MIN_P : step_period;
        period_cur = tick ? period_new : period_q;
        wrap       = (period_cnt == period_cur - 32'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt <= 32'd0;
            period_q   <= MIN_P;
            step_q     <= '0;
        end else if (active) begin
            if (tick) begin
                period_q <= period_new;
            end
            if (wrap) begin
                period_cnt <= 32'd0;
                step_q     <= step_q + 1'b1;
            end else begin
                period_cnt <= period_cnt + 32'd1;
            end
        end else begin
            period_cnt <= 32'd0;
            step_q     <= '0;
        end
    end

    // Stopping clears the pulse counters so no trigger tail survives a stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                trig_cnt[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (!active) begin
                    trig_cnt[v] <= '0;
                end else if (tick && pattern[v][step_q]) begin
                    trig_cnt[v] <= TRIG_LOAD;
                end else if (trig_cnt[v] != '0) begin
                    trig_cnt[v] <= trig_cnt[v] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                pattern[v] <= '0;
            end
        end else if (wr_en && (int'(wr_voice) < NUM_VOICES)) begin
            pattern[wr_voice][wr_step] <= wr_data;
        end
    end

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Directed self-checking bench for drum_step_sequencer with a short trigger
// width (3 cycles) so pulse edges can be observed.
module tb_drum_step_sequencer;

    localparam int NV   = 4;
    localparam int NS   = 16;
    localparam int TRIG = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        play;
    logic [31:0] step_period;
    logic        wr_en;
    logic [1:0]  wr_voice;
    logic [3:0]  wr_step;
    logic        wr_data;
    logic        running;
    logic        step_tick;
    logic [3:0]  step_idx;
    logic [3:0]  trig;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    drum_step_sequencer #(
        .NUM_VOICES (NV),
        .NUM_STEPS  (NS),
        .TRIG_CYCLES(TRIG),
        .MIN_PERIOD (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .play       (play),
        .step_period(step_period),
        .wr_en      (wr_en),
        .wr_voice   (wr_voice),
        .wr_step    (wr_step),
        .wr_data    (wr_data),
        .running    (running),
        .step_tick  (step_tick),
        .step_idx   (step_idx),
        .trig       (trig)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic apply_reset();
        rst   = 1'b1;
        play  = 1'b0;
        wr_en = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic apply_write(input logic [1:0] v, input logic [3:0] s, input logic d);
        wr_en    = 1'b1;
        wr_voice = v;
        wr_step  = s;
        wr_data  = d;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        play        = 1'b0;
        step_period = 32'd0;
        wr_en       = 1'b0;
        wr_voice    = '0;
        wr_step     = '0;
        wr_data     = 1'b0;
        step();
        step();
        check_output("reset_running", running, 0);
        check_output("reset_tick", step_tick, 0);
        check_output("reset_idx", step_idx, 0);
        check_output("reset_trig", trig, 0);
        rst = 1'b0;

        // Single hit on voice 0 step 0, period 10
        apply_write(2'd0, 4'd0, 1'b1);
        step_period = 32'd10;
        play = 1'b1;
        step();
        check_output("t1_running", running, 1);
        check_output("t1_first_tick", step_tick, 1);
        check_output("t1_first_idx", step_idx, 0);
        check_output("t1_trig_at_tick", trig, 0);
        for (int i = 1; i < 10; i++) begin
            step();
            check_output("t1_no_tick", step_tick, 0);
            check_output("t1_trig_width", trig, (i <= TRIG) ? 32'd1 : 32'd0);
        end
        step();
        check_output("t1_second_tick", step_tick, 1);
        check_output("t1_second_idx", step_idx, 1);
        play = 1'b0;
        step();
        check_output("t1_stopped", running, 0);

        // All-ones row 1, period 4, full bar plus wrap
        apply_reset();
        for (int s = 0; s < NS; s++) begin
            apply_write(2'd1, 4'(s), 1'b1);
        end
        step_period = 32'd4;
        play = 1'b1;
        step();
        for (int s = 0; s <= NS; s++) begin
            check_output("t2_tick", step_tick, 1);
            check_output("t2_idx", step_idx, 32'(s % NS));
            check_output("t2_trig_low_at_tick", trig[1], 0);
            for (int k = 1; k < 4; k++) begin
                step();
                check_output("t2_no_tick", step_tick, 0);
                check_output("t2_trig_high", trig[1], 1);
            end
            step();
        end
        play = 1'b0;
        step();

        // Clamp of period 0 to 2, then mid-step period changes
        apply_reset();
        step_period = 32'd0;
        play = 1'b1;
        step();
        check_output("t3_tick0", step_tick, 1);
        step();
        check_output("t3_gap0", step_tick, 0);
        step();
        check_output("t3_tick1", step_tick, 1);
        check_output("t3_idx1", step_idx, 1);
        step();
        check_output("t3_gap1", step_tick, 0);
        step_period = 32'd8;
        step();
        check_output("t3_tick2_old_period", step_tick, 1);
        check_output("t3_idx2", step_idx, 2);
        for (int i = 1; i < 8; i++) begin
            step();
            check_output("t3_period8_gap", step_tick, 0);
            if (i == 1) step_period = 32'd2;
        end
        step();
        check_output("t3_tick3", step_tick, 1);
        check_output("t3_idx3", step_idx, 3);
        step();
        check_output("t3_gap3", step_tick, 0);
        step();
        check_output("t3_tick4", step_tick, 1);
        check_output("t3_idx4", step_idx, 4);
        play = 1'b0;
        step();

        // Stop during an active trigger, then restart
        apply_reset();
        apply_write(2'd0, 4'd1, 1'b1);
        step_period = 32'd10;
        play = 1'b1;
        step();
        check_output("t4_tick0_trig", trig, 0);
        repeat (10) step();
        check_output("t4_tick1", step_tick, 1);
        check_output("t4_idx1", step_idx, 1);
        step();
        check_output("t4_trig_on", trig, 1);
        play = 1'b0;
        step();
        check_output("t4_stop_running", running, 0);
        check_output("t4_stop_trig", trig, 0);
        check_output("t4_stop_idx", step_idx, 0);
        check_output("t4_stop_tick", step_tick, 0);
        step();
        check_output("t4_no_tail", trig, 0);
        play = 1'b1;
        step();
        check_output("t4_restart_running", running, 1);
        check_output("t4_restart_tick", step_tick, 1);
        check_output("t4_restart_idx", step_idx, 0);
        play = 1'b0;
        step();

        // Write to the cell being read at its own tick
        apply_reset();
        apply_write(2'd2, 4'd5, 1'b1);
        step_period = 32'd2;
        play = 1'b1;
        step();
        repeat (10) step();
        check_output("t5_tick5", step_tick, 1);
        check_output("t5_idx5", step_idx, 5);
        wr_en    = 1'b1;
        wr_voice = 2'd2;
        wr_step  = 4'd5;
        wr_data  = 1'b0;
        step();
        wr_en = 1'b0;
        check_output("t5_old_bit_used", trig, 4'b0100);
        repeat (31) step();
        check_output("t5_next_bar_tick", step_tick, 1);
        check_output("t5_next_bar_idx", step_idx, 5);
        step();
        check_output("t5_new_bit_used", trig, 0);
        play = 1'b0;
        step();

        // Reset mid-run overrides a concurrent write
        apply_reset();
        apply_write(2'd3, 4'd0, 1'b1);
        step_period = 32'd4;
        play = 1'b1;
        step();
        step();
        check_output("t6_trig3", trig, 4'b1000);
        step();
        rst      = 1'b1;
        wr_en    = 1'b1;
        wr_voice = 2'd1;
        wr_step  = 4'd0;
        wr_data  = 1'b1;
        step();
        check_output("t6_rst_running", running, 0);
        check_output("t6_rst_tick", step_tick, 0);
        check_output("t6_rst_idx", step_idx, 0);
        check_output("t6_rst_trig", trig, 0);
        rst   = 1'b0;
        wr_en = 1'b0;
        step();
        check_output("t6_rerun_tick", step_tick, 1);
        step();
        check_output("t6_pattern_cleared", trig, 0);
        play = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
